// File: rtl/types_amba_pkg.sv
// Shared AMBA/AXI4 types for the system bus: bus widths, burst and response
// encodings, and the packed AXI4 slave request/response channel bundles.
package types_amba_pkg;

  localparam int unsigned CFG_SYSBUS_ADDR_BITS  = 32;
  localparam int unsigned CFG_SYSBUS_DATA_BITS  = 64;
  localparam int unsigned CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;
  localparam int unsigned CFG_SYSBUS_ID_BITS    = 5;
  localparam int unsigned CFG_SYSBUS_USER_BITS  = 1;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Address-phase payload shared by AR and AW
  typedef struct packed {
    logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
    logic [7:0]                      len;
    logic [2:0]                      size;
    logic [1:0]                      burst;
  } axi4_metadata_type;

  typedef struct packed {
    logic                             aw_valid;
    axi4_metadata_type                aw_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
    logic                             w_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
    logic                             w_last;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
    logic                             b_ready;
    logic                             ar_valid;
    axi4_metadata_type                ar_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
    logic                             r_ready;
  } axi4_slave_in_type;

  typedef struct packed {
    logic                             aw_ready;
    logic                             w_ready;
    logic                             b_valid;
    logic [1:0]                       b_resp;
    logic [CFG_SYSBUS_ID_BITS-1:0]    b_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  b_user;
    logic                             ar_ready;
    logic                             r_valid;
    logic [1:0]                       r_resp;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  r_data;
    logic                             r_last;
    logic [CFG_SYSBUS_ID_BITS-1:0]    r_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  r_user;
  } axi4_slave_out_type;

  // Beats wider than 8 bytes do not exist on this bus; clamp to 3
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > 3'd3) ? 3'd3 : size;
  endfunction

endpackage

// File: rtl/axi4_burst_next_addr.sv
// Combinational AXI4 burst address sequencer.
// Ports: i_addr current beat address, i_len burst length-1, i_size log2 beat
// bytes, i_burst burst type; o_next_addr_c address of the following beat.
module axi4_burst_next_addr
  import types_amba_pkg::*;
(
  input  logic [CFG_SYSBUS_ADDR_BITS-1:0] i_addr,
  input  logic [7:0]                      i_len,
  input  logic [2:0]                      i_size,
  input  logic [1:0]                      i_burst,
  output logic [CFG_SYSBUS_ADDR_BITS-1:0] o_next_addr_c
);

  localparam int unsigned AW = CFG_SYSBUS_ADDR_BITS;

  logic [AW-1:0] w_step;
  logic [AW-1:0] w_mask;
  logic [AW-1:0] w_incr;

  // WRAP keeps the upper bits and wraps the low bits inside a (len+1)*step window
  always_comb begin
    w_step        = AW'(1) << i_size;
    w_mask        = ((AW'(i_len) + AW'(1)) << i_size) - AW'(1);
    w_incr        = i_addr + w_step;
    o_next_addr_c = w_incr;
    case (i_burst)
      AXI_BURST_FIXED: o_next_addr_c = i_addr;
      AXI_BURST_WRAP:  o_next_addr_c = (i_addr & ~w_mask) | (w_incr & w_mask);
      default:         o_next_addr_c = w_incr;
    endcase
  end

endmodule

// File: rtl/axi4_slv_mem.sv
// AXI4 slave that splits read/write bursts into single-beat requests on a
// ready/valid memory port, one transaction at a time.
// Ports: i_clk/i_nrst clock and async active-low reset; i_xslvi/o_xslvo AXI4
// slave channels; o_req_* memory request (valid/ready with i_req_ready);
// i_resp_* one-cycle memory response pulse with read data and error.
module axi4_slv_mem
  import types_amba_pkg::*;
#(
  parameter bit rd_priority = 1'b1
) (
  input  logic                             i_clk,
  input  logic                             i_nrst,
  input  axi4_slave_in_type                i_xslvi,
  output axi4_slave_out_type               o_xslvo,
  output logic                             o_req_valid,
  input  logic                             i_req_ready,
  output logic                             o_req_write,
  output logic [CFG_SYSBUS_ADDR_BITS-1:0]  o_req_addr,
  output logic [2:0]                       o_req_size,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_req_wdata,
  output logic [CFG_SYSBUS_DATA_BYTES-1:0] o_req_wstrb,
  input  logic                             i_resp_valid,
  input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_resp_rdata,
  input  logic                             i_resp_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_BEAT = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_WR_REQ  = 3'd5,
    ST_WR_WAIT = 3'd6,
    ST_WR_RESP = 3'd7
  } state_t;

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic                               r_armed;
  logic                               r_last_wr;
  logic [CFG_SYSBUS_ADDR_BITS-1:0]    r_addr;
  logic [7:0]                         r_len;
  logic [7:0]                         r_cnt;
  logic [2:0]                         r_size;
  logic [1:0]                         r_burst;
  logic [CFG_SYSBUS_ID_BITS-1:0]      r_id;
  logic [CFG_SYSBUS_USER_BITS-1:0]    r_user;
  logic                               r_err;
  logic [CFG_SYSBUS_DATA_BITS-1:0]    r_wdata;
  logic [CFG_SYSBUS_DATA_BYTES-1:0]   r_wstrb;
  logic [CFG_SYSBUS_DATA_BITS-1:0]    r_rdata;
  logic [1:0]                         r_rresp;
  logic                               r_rlast;
  logic                               w_ar_sel;
  logic                               w_aw_sel;
  logic [CFG_SYSBUS_ADDR_BITS-1:0]    w_next_addr;
  logic                               w_unused;

  // WLAST carries no information here: beat count comes from len
  assign w_unused = i_xslvi.w_last;

  axi4_burst_next_addr u_next_addr (
    .i_addr        (r_addr),
    .i_len         (r_len),
    .i_size        (r_size),
    .i_burst       (r_burst),
    .o_next_addr_c (w_next_addr)
  );

  // Address-channel arbitration; r_armed keeps readies low in the first cycle out of reset
  always_comb begin
    w_ar_sel = 1'b0;
    w_aw_sel = 1'b0;
    if ((r_state == ST_IDLE) && r_armed) begin
      if (i_xslvi.ar_valid && i_xslvi.aw_valid) begin
        if (rd_priority || r_last_wr) w_ar_sel = 1'b1;
        else                          w_aw_sel = 1'b1;
      end else begin
        w_ar_sel = i_xslvi.ar_valid;
        w_aw_sel = i_xslvi.aw_valid;
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ar_sel)      w_state_nxt = ST_RD_REQ;
        else if (w_aw_sel) w_state_nxt = ST_WR_DATA;
      end
      ST_RD_REQ:  if (i_req_ready)      w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (i_resp_valid)     w_state_nxt = ST_RD_BEAT;
      ST_RD_BEAT: if (i_xslvi.r_ready)  w_state_nxt = r_rlast ? ST_IDLE : ST_RD_REQ;
      ST_WR_DATA: if (i_xslvi.w_valid)  w_state_nxt = ST_WR_REQ;
      ST_WR_REQ:  if (i_req_ready)      w_state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: if (i_resp_valid)     w_state_nxt = (r_cnt == r_len) ? ST_WR_RESP : ST_WR_DATA;
      ST_WR_RESP: if (i_xslvi.b_ready)  w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  // Transaction context, beat counter and response capture
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_armed   <= 1'b0;
      r_last_wr <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_id      <= '0;
      r_user    <= '0;
      r_err     <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_rlast   <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_ar_sel) begin
            r_addr    <= i_xslvi.ar_bits.addr;
            r_len     <= i_xslvi.ar_bits.len;
            r_size    <= clamp_size(i_xslvi.ar_bits.size);
            r_burst   <= i_xslvi.ar_bits.burst;
            r_id      <= i_xslvi.ar_id;
            r_user    <= i_xslvi.ar_user;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_last_wr <= 1'b0;
          end else if (w_aw_sel) begin
            r_addr    <= i_xslvi.aw_bits.addr;
            r_len     <= i_xslvi.aw_bits.len;
            r_size    <= clamp_size(i_xslvi.aw_bits.size);
            r_burst   <= i_xslvi.aw_bits.burst;
            r_id      <= i_xslvi.aw_id;
            r_user    <= i_xslvi.aw_user;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_last_wr <= 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (i_resp_valid) begin
            r_rdata <= i_resp_rdata;
            r_rresp <= i_resp_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            r_rlast <= (r_cnt == r_len);
          end
        end
        ST_RD_BEAT: begin
          if (i_xslvi.r_ready && !r_rlast) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 8'd1;
          end
        end
        ST_WR_DATA: begin
          if (i_xslvi.w_valid) begin
            r_wdata <= i_xslvi.w_data;
            r_wstrb <= i_xslvi.w_strb;
          end
        end
        ST_WR_WAIT: begin
          if (i_resp_valid) begin
            r_err <= r_err | i_resp_err;
            if (r_cnt != r_len) begin
              r_addr <= w_next_addr;
              r_cnt  <= r_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // AXI4 response channels decoded from state and held registers
  always_comb begin
    o_xslvo          = '0;
    o_xslvo.ar_ready = w_ar_sel;
    o_xslvo.aw_ready = w_aw_sel;
    o_xslvo.w_ready  = (r_state == ST_WR_DATA);
    o_xslvo.b_valid  = (r_state == ST_WR_RESP);
    o_xslvo.b_resp   = r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    o_xslvo.b_id     = r_id;
    o_xslvo.b_user   = r_user;
    o_xslvo.r_valid  = (r_state == ST_RD_BEAT);
    o_xslvo.r_resp   = r_rresp;
    o_xslvo.r_data   = r_rdata;
    o_xslvo.r_last   = r_rlast;
    o_xslvo.r_id     = r_id;
    o_xslvo.r_user   = r_user;
  end

  assign o_req_valid = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
  assign o_req_write = (r_state == ST_WR_REQ);
  assign o_req_addr  = r_addr;
  assign o_req_size  = r_size;
  assign o_req_wdata = r_wdata;
  assign o_req_wstrb = r_wstrb;

endmodule

// File: tb/tb_axi4_slv_mem.sv
// Scoreboard bench for axi4_slv_mem: directed bursts push expected memory
// requests, R beats, B responses and grants; a monitor pops and compares.
`timescale 1ns/1ps
module tb_axi4_slv_mem;
  import types_amba_pkg::*;

  localparam int unsigned AW  = CFG_SYSBUS_ADDR_BITS;
  localparam int unsigned DW  = CFG_SYSBUS_DATA_BITS;
  localparam int unsigned SW  = CFG_SYSBUS_DATA_BYTES;
  localparam int unsigned IDW = CFG_SYSBUS_ID_BITS;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_exp_t;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
    logic [IDW-1:0] id;
  } r_exp_t;

  typedef struct packed {
    logic [1:0]     resp;
    logic [IDW-1:0] id;
  } b_exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } w_beat_t;

  logic i_clk = 1'b0;
  logic i_nrst = 1'b0;
  axi4_slave_in_type  i_xslvi;
  axi4_slave_out_type o_xslvo;
  logic               o_req_valid, i_req_ready, o_req_write;
  logic [AW-1:0]      o_req_addr;
  logic [2:0]         o_req_size;
  logic [DW-1:0]      o_req_wdata, i_resp_rdata;
  logic [SW-1:0]      o_req_wstrb;
  logic               i_resp_valid, i_resp_err;

  // Bench-side channel drivers, assembled into the input bundle
  logic           tb_ar_valid = 1'b0, tb_aw_valid = 1'b0, tb_w_valid = 1'b0;
  logic           tb_r_ready = 1'b1, tb_b_ready = 1'b1;
  axi4_metadata_type tb_ar_bits = '0, tb_aw_bits = '0;
  logic [IDW-1:0] tb_ar_id = '0, tb_aw_id = '0;
  logic [DW-1:0]  tb_w_data = '0;
  logic [SW-1:0]  tb_w_strb = '0;

  req_exp_t q_req[$];
  r_exp_t   q_r[$];
  b_exp_t   q_b[$];
  logic     q_grant[$];   // 0 = AR, 1 = AW
  w_beat_t  q_w[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        hold_resp = 1'b0;
  logic [AW-1:0] err_addr = 32'hFFFF_FFFF;
  int          r_stall = 0;

  always #5 i_clk = ~i_clk;

  always_comb begin
    i_xslvi          = '0;
    i_xslvi.ar_valid = tb_ar_valid;
    i_xslvi.ar_bits  = tb_ar_bits;
    i_xslvi.ar_id    = tb_ar_id;
    i_xslvi.aw_valid = tb_aw_valid;
    i_xslvi.aw_bits  = tb_aw_bits;
    i_xslvi.aw_id    = tb_aw_id;
    i_xslvi.w_valid  = tb_w_valid;
    i_xslvi.w_data   = tb_w_data;
    i_xslvi.w_strb   = tb_w_strb;
    i_xslvi.r_ready  = tb_r_ready;
    i_xslvi.b_ready  = tb_b_ready;
  end

  axi4_slv_mem #(.rd_priority(1'b0)) dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_xslvi      (i_xslvi),
    .o_xslvo      (o_xslvo),
    .o_req_valid  (o_req_valid),
    .i_req_ready  (i_req_ready),
    .o_req_write  (o_req_write),
    .o_req_addr   (o_req_addr),
    .o_req_size   (o_req_size),
    .o_req_wdata  (o_req_wdata),
    .o_req_wstrb  (o_req_wstrb),
    .i_resp_valid (i_resp_valid),
    .i_resp_rdata (i_resp_rdata),
    .i_resp_err   (i_resp_err)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Memory model: data at address a is {~a, a}; response one cycle after acceptance
  initial begin : mem_model
    logic          acc;
    logic [AW-1:0] a;
    int unsigned   cyc;
    cyc = 0;
    i_req_ready = 1'b0; i_resp_valid = 1'b0; i_resp_rdata = '0; i_resp_err = 1'b0;
    forever begin
      @(negedge i_clk);
      acc = o_req_valid && i_req_ready && i_nrst;
      a   = o_req_addr;
      @(posedge i_clk); #1;
      cyc++;
      i_resp_valid = 1'b0;
      i_resp_err   = 1'b0;
      if (acc && !hold_resp) begin
        i_resp_valid = 1'b1;
        i_resp_rdata = DW'({~a, a});
        i_resp_err   = (a == err_addr);
      end
      i_req_ready = (cyc % 4) != 0;
    end
  end

  // W driver presents queued beats in order
  initial begin : w_drv
    forever begin
      @(posedge i_clk); #1;
      if (q_w.size() > 0) begin
        tb_w_valid = 1'b1; tb_w_data = q_w[0].data; tb_w_strb = q_w[0].strb;
      end else begin
        tb_w_valid = 1'b0;
      end
      @(negedge i_clk);
      if (tb_w_valid && o_xslvo.w_ready) q_w.delete(0);
    end
  end

  // R back-pressure: hold r_ready low for r_stall cycles of r_valid
  initial begin : r_drv
    forever begin
      @(posedge i_clk); #1;
      if (o_xslvo.r_valid && r_stall > 0) begin
        tb_r_ready = 1'b0; r_stall--;
      end else begin
        tb_r_ready = 1'b1;
      end
    end
  end

  // Monitor: pops expectations on every handshake, checks stability under back-pressure
  initial begin : monitor
    req_exp_t er, rq_snap;
    r_exp_t   rr, r_snap;
    b_exp_t   bb;
    logic     g;
    logic     rq_wait, r_wait;
    rq_wait = 1'b0; r_wait = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_nrst) begin
        rq_wait = 1'b0; r_wait = 1'b0;
      end else begin
        check("ready_excl", 128'(o_xslvo.ar_ready && o_xslvo.aw_ready), 128'(0));
        if (tb_ar_valid && o_xslvo.ar_ready) begin
          if (q_grant.size() == 0) check("unexp_ar_grant", 128'(1), 128'(0));
          else begin g = q_grant.pop_front(); check("grant", 128'(0), 128'(g)); end
        end
        if (tb_aw_valid && o_xslvo.aw_ready) begin
          if (q_grant.size() == 0) check("unexp_aw_grant", 128'(1), 128'(0));
          else begin g = q_grant.pop_front(); check("grant", 128'(1), 128'(g)); end
        end
        if (rq_wait) begin
          check("req_valid_held", 128'(o_req_valid), 128'(1));
          check("req_stable", 128'({o_req_write, o_req_addr, o_req_size, o_req_wdata, o_req_wstrb}),
                128'(rq_snap));
        end
        rq_wait = o_req_valid && !i_req_ready;
        rq_snap = {o_req_write, o_req_addr, o_req_size, o_req_wdata, o_req_wstrb};
        if (o_req_valid && i_req_ready) begin
          if (q_req.size() == 0) check("unexp_req", 128'(o_req_addr), 128'(0));
          else begin
            er = q_req.pop_front();
            check("req_cmd", 128'({o_req_write, o_req_addr, o_req_size}),
                  128'({er.write, er.addr, er.size}));
            if (er.write) check("req_wdata", 128'({o_req_wdata, o_req_wstrb}), 128'({er.wdata, er.wstrb}));
          end
        end
        if (r_wait) begin
          check("r_valid_held", 128'(o_xslvo.r_valid), 128'(1));
          check("r_stable", 128'({o_xslvo.r_data, o_xslvo.r_resp, o_xslvo.r_last, o_xslvo.r_id}),
                128'(r_snap));
        end
        r_wait = o_xslvo.r_valid && !tb_r_ready;
        r_snap = {o_xslvo.r_data, o_xslvo.r_resp, o_xslvo.r_last, o_xslvo.r_id};
        if (o_xslvo.r_valid && tb_r_ready) begin
          if (q_r.size() == 0) check("unexp_r", 128'(o_xslvo.r_data), 128'(0));
          else begin
            rr = q_r.pop_front();
            check("r_beat", 128'({o_xslvo.r_data, o_xslvo.r_resp, o_xslvo.r_last, o_xslvo.r_id}),
                  128'(rr));
          end
        end
        if (o_xslvo.b_valid && tb_b_ready) begin
          if (q_b.size() == 0) check("unexp_b", 128'(o_xslvo.b_id), 128'(0));
          else begin
            bb = q_b.pop_front();
            check("b_resp", 128'({o_xslvo.b_resp, o_xslvo.b_id}), 128'(bb));
          end
        end
      end
    end
  end

  task automatic issue_ar(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [IDW-1:0] id);
    logic got;
    got = 1'b0;
    @(posedge i_clk); #1;
    tb_ar_bits = '{addr: addr, len: len, size: size, burst: burst};
    tb_ar_id = id; tb_ar_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (o_xslvo.ar_ready) begin got = 1'b1; break; end
    end
    @(posedge i_clk); #1;
    tb_ar_valid = 1'b0;
    if (!got) check("ar_timeout", 128'(0), 128'(1));
  endtask

  task automatic issue_aw(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [IDW-1:0] id);
    logic got;
    got = 1'b0;
    @(posedge i_clk); #1;
    tb_aw_bits = '{addr: addr, len: len, size: size, burst: burst};
    tb_aw_id = id; tb_aw_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (o_xslvo.aw_ready) begin got = 1'b1; break; end
    end
    @(posedge i_clk); #1;
    tb_aw_valid = 1'b0;
    if (!got) check("aw_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_drain(input string nm);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge i_clk);
      if (q_req.size() == 0 && q_r.size() == 0 && q_b.size() == 0 && q_grant.size() == 0) begin
        done = 1'b1; break;
      end
    end
    if (!done) check({nm, "_drain_timeout"}, 128'(q_req.size() + q_r.size() + q_b.size()), 128'(0));
    repeat (2) @(posedge i_clk);
  endtask

  task automatic push_rd(input logic [AW-1:0] addr, input logic [2:0] size, input logic [DW-1:0] data,
                         input logic last, input logic [IDW-1:0] id);
    q_req.push_back('{write: 1'b0, addr: addr, size: size, wdata: '0, wstrb: '0});
    q_r.push_back('{data: data, resp: AXI_RESP_OKAY, last: last, id: id});
  endtask

  task automatic rr_round();
    q_grant.push_back(1'b0);
    q_grant.push_back(1'b1);
    push_rd(32'h5000, 3'd3, 64'hFFFF_AFFF_0000_5000, 1'b1, 5'd1);
    q_req.push_back('{write: 1'b1, addr: 32'h6000, size: 3'd3, wdata: 64'h0123_4567_89AB_CDEF, wstrb: 8'hFF});
    q_b.push_back('{resp: AXI_RESP_OKAY, id: 5'd2});
    q_w.push_back('{data: 64'h0123_4567_89AB_CDEF, strb: 8'hFF});
    fork
      issue_ar(32'h5000, 8'd0, 3'd3, AXI_BURST_INCR, 5'd1);
      issue_aw(32'h6000, 8'd0, 3'd3, AXI_BURST_INCR, 5'd2);
    join
    wait_drain("rr");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_axi_out", 128'(o_xslvo), 128'(0));
    check("rst_req_out", 128'({o_req_valid, o_req_write, o_req_addr, o_req_size, o_req_wdata, o_req_wstrb}), 128'(0));
    i_nrst = 1'b1;

    // Single read
    q_grant.push_back(1'b0);
    push_rd(32'h1000, 3'd3, 64'hFFFF_EFFF_0000_1000, 1'b1, 5'd5);
    issue_ar(32'h1000, 8'd0, 3'd3, AXI_BURST_INCR, 5'd5);
    wait_drain("single_rd");

    // INCR read with R back-pressure on the first beat
    q_grant.push_back(1'b0);
    push_rd(32'h2004, 3'd2, 64'hFFFF_DFFB_0000_2004, 1'b0, 5'd9);
    push_rd(32'h2008, 3'd2, 64'hFFFF_DFF7_0000_2008, 1'b0, 5'd9);
    push_rd(32'h200C, 3'd2, 64'hFFFF_DFF3_0000_200C, 1'b0, 5'd9);
    push_rd(32'h2010, 3'd2, 64'hFFFF_DFEF_0000_2010, 1'b1, 5'd9);
    r_stall = 5;
    issue_ar(32'h2004, 8'd3, 3'd2, AXI_BURST_INCR, 5'd9);
    wait_drain("incr_rd");

    // WRAP read, size field above 3 clamps to 8-byte beats
    q_grant.push_back(1'b0);
    push_rd(32'h3018, 3'd3, 64'hFFFF_CFE7_0000_3018, 1'b0, 5'd4);
    push_rd(32'h3000, 3'd3, 64'hFFFF_CFFF_0000_3000, 1'b0, 5'd4);
    push_rd(32'h3008, 3'd3, 64'hFFFF_CFF7_0000_3008, 1'b0, 5'd4);
    push_rd(32'h3010, 3'd3, 64'hFFFF_CFEF_0000_3010, 1'b1, 5'd4);
    issue_ar(32'h3018, 8'd3, 3'd6, AXI_BURST_WRAP, 5'd4);
    wait_drain("wrap_rd");

    // Two-beat write, error on second beat gives SLVERR
    err_addr = 32'h4008;
    q_grant.push_back(1'b1);
    q_req.push_back('{write: 1'b1, addr: 32'h4000, size: 3'd3, wdata: 64'h1122_3344_5566_7788, wstrb: 8'hFF});
    q_req.push_back('{write: 1'b1, addr: 32'h4008, size: 3'd3, wdata: 64'hAABB_CCDD_EEFF_0011, wstrb: 8'h0F});
    q_b.push_back('{resp: AXI_RESP_SLVERR, id: 5'd3});
    q_w.push_back('{data: 64'h1122_3344_5566_7788, strb: 8'hFF});
    q_w.push_back('{data: 64'hAABB_CCDD_EEFF_0011, strb: 8'h0F});
    issue_aw(32'h4000, 8'd1, 3'd3, AXI_BURST_INCR, 5'd3);
    wait_drain("wr_err");
    err_addr = 32'hFFFF_FFFF;

    // Simultaneous AR/AW twice: last grant was AW, so AR, AW, AR, AW
    rr_round();
    rr_round();

    // Reset while waiting for the first response of a 4-beat read
    hold_resp = 1'b1;
    q_grant.push_back(1'b0);
    q_req.push_back('{write: 1'b0, addr: 32'h7000, size: 3'd3, wdata: '0, wstrb: '0});
    issue_ar(32'h7000, 8'd3, 3'd3, AXI_BURST_INCR, 5'd6);
    wait_drain("rst_rd");
    check("pre_rst_addr", 128'({o_xslvo.r_id, o_req_addr}), 128'({5'd6, 32'h7000}));
    #1;
    i_nrst = 1'b0;
    #1;
    check("midrst_axi_out", 128'(o_xslvo), 128'(0));
    check("midrst_req_out", 128'({o_req_valid, o_req_write, o_req_addr, o_req_size, o_req_wdata, o_req_wstrb}), 128'(0));
    repeat (2) @(posedge i_clk);
    #1;
    hold_resp = 1'b0;
    i_nrst = 1'b1;

    // A new single read completes normally after reset
    q_grant.push_back(1'b0);
    push_rd(32'h1000, 3'd3, 64'hFFFF_EFFF_0000_1000, 1'b1, 5'd7);
    issue_ar(32'h1000, 8'd0, 3'd3, AXI_BURST_INCR, 5'd7);
    wait_drain("post_rst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
